// File: rtl/fetch_unit_if.sv
// fetch_unit_if: instruction-memory port, decoder handshake and redirect bundle.
`default_nettype none

interface fetch_unit_if #(
  parameter int DATA_W = 16,
  parameter int ADDR_W = 16,
  parameter int DEPTH  = 4
);
  localparam int CW = $clog2(DEPTH + 1);

  logic              imem_req;
  logic [ADDR_W-1:0] imem_addr;
  logic              imem_ack;
  logic [DATA_W-1:0] imem_rdata;
  logic              inst_valid;
  logic [DATA_W-1:0] inst_data;
  logic [ADDR_W-1:0] inst_pc;
  logic              inst_ready;
  logic              redirect;
  logic [ADDR_W-1:0] redirect_pc;
  logic [CW-1:0]     count;

  modport master (
    output imem_req, imem_addr, inst_valid, inst_data, inst_pc, count,
    input  imem_ack, imem_rdata, inst_ready, redirect, redirect_pc
  );

  modport slave (
    input  imem_req, imem_addr, inst_valid, inst_data, inst_pc, count,
    output imem_ack, imem_rdata, inst_ready, redirect, redirect_pc
  );
endinterface

`default_nettype wire

// File: rtl/fetch_unit.sv
// ============================================================================
// fetch_unit : PC generator, single-outstanding imem port, prefetch queue
//              with branch/jump redirect and in-flight read disposal.
// Revision   : 1.0
// ============================================================================
`default_nettype none

module fetch_unit #(
  parameter int                DATA_W   = 16,
  parameter int                ADDR_W   = 16,
  parameter int                DEPTH    = 4,
  parameter logic [ADDR_W-1:0] RESET_PC = '0
) (
  input  wire          clk,
  input  wire          rst_n,
  fetch_unit_if.master bus
);
  localparam int CW = $clog2(DEPTH + 1);
  localparam int PW = $clog2(DEPTH);
  localparam logic [CW-1:0] c_depth = CW'(DEPTH);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    WAIT  = 2'd1,
    DRAIN = 2'd2
  } state_t;

  state_t            r_state;
  logic              r_req;
  logic [ADDR_W-1:0] r_addr;
  logic [ADDR_W-1:0] r_fetch_pc;
  logic              r_valid;
  logic [DATA_W-1:0] r_data;
  logic [ADDR_W-1:0] r_pc;
  logic [CW-1:0]     r_count;
  logic [PW-1:0]     r_wr_ptr;
  logic [PW-1:0]     r_rd_ptr;
  logic [DATA_W-1:0] r_q_data [DEPTH];
  logic [ADDR_W-1:0] r_q_pc   [DEPTH];

  logic              w_deq;
  logic              w_enq;
  logic [CW-1:0]     w_count_nxt;
  logic              w_room;
  logic [PW-1:0]     w_rd_ptr_nxt;
  logic [PW-1:0]     w_wr_ptr_nxt;
  logic              w_bypass;
  logic [ADDR_W-1:0] w_pc_inc;

  assign w_deq        = r_valid & bus.inst_ready;
  // Acked data is kept only in WAIT; a redirect in the same cycle drops it.
  assign w_enq        = (r_state == WAIT) & bus.imem_ack & ~bus.redirect;
  assign w_count_nxt  = bus.redirect ? '0 : (r_count + CW'(w_enq) - CW'(w_deq));
  assign w_room       = (w_count_nxt < c_depth);
  assign w_rd_ptr_nxt = bus.redirect ? '0 : (r_rd_ptr + PW'(w_deq));
  assign w_wr_ptr_nxt = bus.redirect ? '0 : (r_wr_ptr + PW'(w_enq));
  // Word written into an otherwise empty queue becomes the head directly.
  assign w_bypass     = w_enq & (r_count == CW'(w_deq));
  assign w_pc_inc     = r_fetch_pc + ADDR_W'(1);

  always_ff @(posedge clk) begin
    if (w_enq) begin
      r_q_data[r_wr_ptr] <= bus.imem_rdata;
      r_q_pc[r_wr_ptr]   <= r_addr;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state    <= IDLE;
      r_req      <= 1'b0;
      r_addr     <= RESET_PC;
      r_fetch_pc <= RESET_PC;
      r_valid    <= 1'b0;
      r_data     <= '0;
      r_pc       <= '0;
      r_count    <= '0;
      r_wr_ptr   <= '0;
      r_rd_ptr   <= '0;
    end else begin
      r_count  <= w_count_nxt;
      r_wr_ptr <= w_wr_ptr_nxt;
      r_rd_ptr <= w_rd_ptr_nxt;
      r_valid  <= (w_count_nxt != '0);
      if (w_count_nxt != '0) begin
        r_data <= w_bypass ? bus.imem_rdata : r_q_data[w_rd_ptr_nxt];
        r_pc   <= w_bypass ? r_addr         : r_q_pc[w_rd_ptr_nxt];
      end

      case (r_state)
        IDLE: begin
          if (bus.redirect) begin
            r_fetch_pc <= bus.redirect_pc;
            r_addr     <= bus.redirect_pc;
            r_req      <= 1'b1;
            r_state    <= WAIT;
          end else if (w_room) begin
            r_addr  <= r_fetch_pc;
            r_req   <= 1'b1;
            r_state <= WAIT;
          end
        end
        WAIT: begin
          if (bus.redirect) begin
            r_fetch_pc <= bus.redirect_pc;
            if (bus.imem_ack) begin
              r_addr <= bus.redirect_pc;
            end else begin
              r_state <= DRAIN;
            end
          end else if (bus.imem_ack) begin
            r_fetch_pc <= w_pc_inc;
            if (w_room) begin
              r_addr <= w_pc_inc;
            end else begin
              r_req   <= 1'b0;
              r_state <= IDLE;
            end
          end
        end
        DRAIN: begin
          // Request stays up at the stale address until memory answers it.
          if (bus.redirect) begin
            r_fetch_pc <= bus.redirect_pc;
          end
          if (bus.imem_ack) begin
            r_addr  <= bus.redirect ? bus.redirect_pc : r_fetch_pc;
            r_state <= WAIT;
          end
        end
        default: begin
          r_req   <= 1'b0;
          r_state <= IDLE;
        end
      endcase
    end
  end

  assign bus.imem_req   = r_req;
  assign bus.imem_addr  = r_addr;
  assign bus.inst_valid = r_valid;
  assign bus.inst_data  = r_data;
  assign bus.inst_pc    = r_pc;
  assign bus.count      = r_count;
endmodule

`default_nettype wire

// File: tb/tb_fetch_unit.sv
// tb_fetch_unit: directed checks of fetch_unit streaming, fill, redirect and wrap.
`default_nettype none

module tb_fetch_unit;
  logic clk;
  logic rst_n0;
  logic rst_n1;
  int   tests_run;
  int   tests_failed;

  fetch_unit_if #(.DATA_W(16), .ADDR_W(16), .DEPTH(4)) bus0 ();
  fetch_unit_if #(.DATA_W(16), .ADDR_W(16), .DEPTH(4)) bus1 ();

  fetch_unit #(.DATA_W(16), .ADDR_W(16), .DEPTH(4), .RESET_PC(16'h0000)) u_dut0 (
    .clk   (clk),
    .rst_n (rst_n0),
    .bus   (bus0)
  );

  fetch_unit #(.DATA_W(16), .ADDR_W(16), .DEPTH(4), .RESET_PC(16'hFFFE)) u_dut1 (
    .clk   (clk),
    .rst_n (rst_n1),
    .bus   (bus1)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [15:0] mk(input logic [15:0] a);
    return a ^ 16'hC3A5;
  endfunction

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    tests_run++;
    if (got !== exp) begin
      tests_failed++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic chk_head0(input string tag, input logic [15:0] pc, input int cnt);
    check({tag, " valid"}, 32'(bus0.inst_valid), 32'd1);
    check({tag, " pc"},    32'(bus0.inst_pc),    32'(pc));
    check({tag, " data"},  32'(bus0.inst_data),  32'(mk(pc)));
    check({tag, " count"}, 32'(bus0.count),      32'(cnt));
  endtask

  initial begin
    tests_run = 0;
    tests_failed = 0;
    rst_n0 = 1'b0;
    rst_n1 = 1'b0;
    bus0.imem_ack = 1'b0;  bus0.imem_rdata = '0;  bus0.inst_ready = 1'b0;
    bus0.redirect = 1'b0;  bus0.redirect_pc = '0;
    bus1.imem_ack = 1'b0;  bus1.imem_rdata = '0;  bus1.inst_ready = 1'b1;
    bus1.redirect = 1'b0;  bus1.redirect_pc = '0;
    #1;
    check("rst req",   32'(bus0.imem_req),   32'd0);
    check("rst addr",  32'(bus0.imem_addr),  32'd0);
    check("rst valid", 32'(bus0.inst_valid), 32'd0);
    check("rst data",  32'(bus0.inst_data),  32'd0);
    check("rst pc",    32'(bus0.inst_pc),    32'd0);
    check("rst count", 32'(bus0.count),      32'd0);
    tick;
    tick;
    rst_n0 = 1'b1;
    tick;
    check("first req",  32'(bus0.imem_req),  32'd1);
    check("first addr", 32'(bus0.imem_addr), 32'd0);

    // Streaming: ack every cycle, decoder always ready.
    bus0.inst_ready = 1'b1;
    for (int i = 0; i < 6; i++) begin
      bus0.imem_ack = 1'b1;
      bus0.imem_rdata = mk(16'(i));
      tick;
      check("stream addr", 32'(bus0.imem_addr), 32'(i + 1));
      chk_head0("stream", 16'(i), 1);
    end
    bus0.imem_ack = 1'b0;
    tick;
    check("stream empty valid", 32'(bus0.inst_valid), 32'd0);
    check("stream empty count", 32'(bus0.count),      32'd0);

    // Fill the queue with the decoder stalled.
    bus0.inst_ready = 1'b0;
    for (int i = 0; i < 4; i++) begin
      bus0.imem_ack = 1'b1;
      bus0.imem_rdata = mk(16'(6 + i));
      tick;
      check("fill count", 32'(bus0.count), 32'(i + 1));
    end
    bus0.imem_ack = 1'b0;
    check("full req", 32'(bus0.imem_req), 32'd0);
    chk_head0("full head", 16'd6, 4);
    tick;
    tick;
    check("full req hold", 32'(bus0.imem_req), 32'd0);
    bus0.inst_ready = 1'b1;
    tick;
    bus0.inst_ready = 1'b0;
    check("refill req",  32'(bus0.imem_req),  32'd1);
    check("refill addr", 32'(bus0.imem_addr), 32'd10);
    chk_head0("after pop", 16'd7, 3);

    // Enqueue and dequeue in the same cycle at count 3.
    bus0.imem_ack = 1'b1;
    bus0.imem_rdata = mk(16'd10);
    bus0.inst_ready = 1'b1;
    tick;
    bus0.imem_ack = 1'b0;
    chk_head0("enq+deq", 16'd8, 3);
    check("enq+deq addr", 32'(bus0.imem_addr), 32'd11);
    tick;
    chk_head0("order", 16'd9, 2);
    tick;
    chk_head0("order", 16'd10, 1);
    tick;
    check("drained valid", 32'(bus0.inst_valid), 32'd0);

    // Redirect while a request is outstanding with no ack.
    bus0.redirect = 1'b1;
    bus0.redirect_pc = 16'h0100;
    tick;
    bus0.redirect = 1'b0;
    check("redir valid", 32'(bus0.inst_valid), 32'd0);
    check("redir count", 32'(bus0.count),      32'd0);
    check("drain req",   32'(bus0.imem_req),   32'd1);
    check("drain addr",  32'(bus0.imem_addr),  32'd11);
    tick;
    tick;
    check("drain hold addr", 32'(bus0.imem_addr), 32'd11);
    bus0.imem_ack = 1'b1;
    bus0.imem_rdata = mk(16'd11);
    tick;
    bus0.imem_ack = 1'b0;
    check("drop valid",   32'(bus0.inst_valid), 32'd0);
    check("restart req",  32'(bus0.imem_req),   32'd1);
    check("restart addr", 32'(bus0.imem_addr),  32'h100);
    tick;
    check("drop valid 2", 32'(bus0.inst_valid), 32'd0);
    bus0.imem_ack = 1'b1;
    bus0.imem_rdata = mk(16'h0100);
    bus0.inst_ready = 1'b0;
    tick;
    bus0.imem_ack = 1'b0;
    chk_head0("redir first", 16'h0100, 1);
    check("redir next addr", 32'(bus0.imem_addr), 32'h101);

    // Redirect together with ack and a pop.
    bus0.imem_ack = 1'b1;
    bus0.imem_rdata = mk(16'h0101);
    bus0.inst_ready = 1'b1;
    bus0.redirect = 1'b1;
    bus0.redirect_pc = 16'h0200;
    tick;
    bus0.imem_ack = 1'b0;
    bus0.redirect = 1'b0;
    bus0.inst_ready = 1'b0;
    check("coinc valid", 32'(bus0.inst_valid), 32'd0);
    check("coinc count", 32'(bus0.count),      32'd0);
    check("coinc req",   32'(bus0.imem_req),   32'd1);
    check("coinc addr",  32'(bus0.imem_addr),  32'h200);
    bus0.imem_ack = 1'b1;
    bus0.imem_rdata = mk(16'h0200);
    tick;
    bus0.imem_ack = 1'b0;
    chk_head0("coinc resume", 16'h0200, 1);

    // Second instance: address wrap from RESET_PC 0xFFFE and mid-WAIT reset.
    rst_n1 = 1'b1;
    tick;
    check("wrap req",   32'(bus1.imem_req),  32'd1);
    check("wrap addr0", 32'(bus1.imem_addr), 32'hFFFE);
    bus1.imem_ack = 1'b1;
    bus1.imem_rdata = mk(16'hFFFE);
    tick;
    check("wrap addr1", 32'(bus1.imem_addr), 32'hFFFF);
    check("wrap pc0",   32'(bus1.inst_pc),   32'hFFFE);
    check("wrap data0", 32'(bus1.inst_data), 32'(mk(16'hFFFE)));
    bus1.imem_rdata = mk(16'hFFFF);
    tick;
    bus1.imem_ack = 1'b0;
    check("wrap addr2", 32'(bus1.imem_addr), 32'h0000);
    check("wrap pc1",   32'(bus1.inst_pc),   32'hFFFF);
    tick;
    check("wait req", 32'(bus1.imem_req), 32'd1);
    rst_n1 = 1'b0;
    #1;
    check("async req",   32'(bus1.imem_req),   32'd0);
    check("async addr",  32'(bus1.imem_addr),  32'hFFFE);
    check("async valid", 32'(bus1.inst_valid), 32'd0);
    check("async data",  32'(bus1.inst_data),  32'd0);
    check("async pc",    32'(bus1.inst_pc),    32'd0);
    check("async count", 32'(bus1.count),      32'd0);
    #1;
    rst_n1 = 1'b1;
    bus1.imem_ack = 1'b1;
    bus1.imem_rdata = 16'hDEAD;
    tick;
    bus1.imem_ack = 1'b0;
    check("stray count", 32'(bus1.count),      32'd0);
    check("stray valid", 32'(bus1.inst_valid), 32'd0);
    check("stray req",   32'(bus1.imem_req),   32'd1);
    check("stray addr",  32'(bus1.imem_addr),  32'hFFFE);
    tick;
    check("stray valid 2", 32'(bus1.inst_valid), 32'd0);

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end
endmodule

`default_nettype wire
